// File: rtl/scrambler_sequencer.sv
// 802.11a transmit scrambler frame sequencer: SERVICE, PSDU, tail and pad
// emitted through an x^7+x^4+1 scrambler over valid/ready bit handshakes.
module scrambler_sequencer #(
  parameter int N_DBPS = 24,
  parameter int LEN_W  = 12
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [6:0]       Seed,
  input  logic [LEN_W-1:0] Length,
  input  logic             In_Bit,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic             Out_Bit,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic             Busy,
  output logic             Done,
  output logic             Err
);

  localparam int SW = $clog2(N_DBPS);
  localparam int BW = LEN_W + 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVICE,
    S_DATA,
    S_TAIL,
    S_PAD,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [6:0]       lfsr_q, lfsr_d;
  logic [LEN_W-1:0] len_q;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [SW-1:0]    sym_q, sym_d;
  logic             err_q;

  logic          fb;
  logic          beat;
  logic          bit_last;
  logic [BW-1:0] data_last;

  assign fb        = lfsr_q[6] ^ lfsr_q[3];
  assign beat      = Out_Valid & Out_Ready;
  assign data_last = {len_q, 3'b000} - BW'(1);
  assign lfsr_d    = {lfsr_q[5:0], fb};
  assign bcnt_d    = bit_last ? '0 : bcnt_q + BW'(1);
  assign sym_d     = (sym_q == SW'(N_DBPS - 1)) ? '0
                                                : sym_q + SW'(1);

  assign Busy = (state_q != S_IDLE);
  assign Done = (state_q == S_DONE);
  assign Err  = err_q;

  // DATA passes the upstream handshake straight through to the encoder
  always_comb begin
    Out_Bit   = 1'b0;
    Out_Valid = 1'b0;
    In_Ready  = 1'b0;
    bit_last  = 1'b0;
    unique case (state_q)
      S_SERVICE: begin
        Out_Bit   = fb;
        Out_Valid = 1'b1;
        bit_last  = (bcnt_q == BW'(15));
      end
      S_DATA: begin
        Out_Bit   = In_Bit ^ fb;
        Out_Valid = In_Valid;
        In_Ready  = Out_Ready;
        bit_last  = (bcnt_q == data_last);
      end
      S_TAIL: begin
        Out_Valid = 1'b1;
        bit_last  = (bcnt_q == BW'(5));
      end
      S_PAD: begin
        Out_Bit   = fb;
        Out_Valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= 7'h7F;
      len_q   <= '0;
      bcnt_q  <= '0;
      sym_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (Start) begin
            if (Seed == 7'd0 || Length == '0) begin
              err_q <= 1'b1;
            end else begin
              lfsr_q  <= Seed;
              len_q   <= Length;
              bcnt_q  <= '0;
              sym_q   <= '0;
              state_q <= S_SERVICE;
            end
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: begin
          if (beat) begin
            lfsr_q <= lfsr_d;
            bcnt_q <= bcnt_d;
            sym_q  <= sym_d;
            unique case (1'b1)
              state_q == S_SERVICE && bit_last:
                state_q <= S_DATA;
              state_q == S_DATA && bit_last:
                state_q <= S_TAIL;
              state_q == S_TAIL && bit_last:
                state_q <= (sym_d != '0) ? S_PAD : S_DONE;
              state_q == S_PAD && sym_d == '0:
                state_q <= S_DONE;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scrambler_sequencer.sv
// Bench for scrambler_sequencer: three symbol sizes side by side,
// table frames, random backpressure, reset abort and held Start.
module tb_scrambler_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  seed = 7'h7F;
  logic [11:0] length = '0;
  logic        in_bit = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;

  logic [2:0] ir, ob, ov, bz, dn, er;

  always #5 clk = ~clk;

  scrambler_sequencer #(.N_DBPS(24), .LEN_W(12)) u24 (
    .Clock(clk), .Reset_n(rst_n), .Start(start), .Seed(seed),
    .Length(length), .In_Bit(in_bit), .In_Valid(in_valid),
    .In_Ready(ir[0]), .Out_Bit(ob[0]), .Out_Valid(ov[0]),
    .Out_Ready(out_ready), .Busy(bz[0]), .Done(dn[0]), .Err(er[0])
  );

  scrambler_sequencer #(.N_DBPS(48), .LEN_W(12)) u48 (
    .Clock(clk), .Reset_n(rst_n), .Start(start), .Seed(seed),
    .Length(length), .In_Bit(in_bit), .In_Valid(in_valid),
    .In_Ready(ir[1]), .Out_Bit(ob[1]), .Out_Valid(ov[1]),
    .Out_Ready(out_ready), .Busy(bz[1]), .Done(dn[1]), .Err(er[1])
  );

  scrambler_sequencer #(.N_DBPS(2), .LEN_W(12)) u2 (
    .Clock(clk), .Reset_n(rst_n), .Start(start), .Seed(seed),
    .Length(length), .In_Bit(in_bit), .In_Valid(in_valid),
    .In_Ready(ir[2]), .Out_Bit(ob[2]), .Out_Valid(ov[2]),
    .Out_Ready(out_ready), .Busy(bz[2]), .Done(dn[2]), .Err(er[2])
  );

  typedef struct {
    logic [6:0] sd;
    int         len;
    bit         zero;
    bit         stall;
    int         t0, t1, t2;
    bit         xerr;
  } vec_t;

  vec_t tbl[9];
  int   errors = 0;
  int   checks = 0;
  bit   fdat[$];
  bit   cap0[$], cap1[$], cap2[$];
  bit   expq[$];
  int   ndone[3];
  int   done_cyc[3];
  int   first_ov;

  task automatic chk(input bit ok, input string nm,
                     input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Scrambler as the recurrence p[k] = p[k-7] ^ p[k-4], seed gives p[-7..-1]
  task automatic build_exp(input logic [6:0] sd, input int len,
                           input int n);
    bit p[$];
    int body;
    int tot;
    bit pk;
    body = 22 + 8 * len;
    tot  = body + (n - body % n) % n;
    expq.delete();
    for (int i = 6; i >= 0; i--) p.push_back(sd[i]);
    for (int k = 0; k < tot; k++) begin
      pk = p[k] ^ p[k+3];
      p.push_back(pk);
      if (k >= 16 && k < 16 + 8 * len) expq.push_back(pk ^ fdat[k-16]);
      else if (k >= 16 + 8 * len && k < body) expq.push_back(1'b0);
      else expq.push_back(pk);
    end
  endtask

  task automatic cmp_model(input int d, input logic [6:0] sd,
                           input int len, input int n, input int hand,
                           input string tag);
    bit c[$];
    int bad;
    if (d == 0) c = cap0;
    else if (d == 1) c = cap1;
    else c = cap2;
    build_exp(sd, len, n);
    chk(c.size() == hand, {tag, " beats"}, c.size(), hand);
    bad = -1;
    for (int i = 0; i < expq.size(); i++) begin
      if (i >= c.size() || c[i] != expq[i]) begin
        bad = i;
        break;
      end
    end
    chk(bad < 0, {tag, " bits first bad idx"}, bad, -1);
  endtask

  function automatic int cap_bits(input int s, input int n);
    int v;
    v = 0;
    if (cap0.size() < s + n) return -1;
    for (int i = s; i < s + n; i++) v = (v << 1) | int'(cap0[i]);
    return v;
  endfunction

  task automatic wait_idle(input string tag);
    int c;
    start = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    c = 0;
    @(negedge clk);
    while (bz != 3'b000 && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk(bz == 3'b000, {tag, " idle"}, int'(bz), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [6:0] sd, input int len,
                           input bit zero, input bit stall,
                           input int h0, input int h1, input int h2,
                           input bit xerr, input string tag);
    int di, nb0, nerr, nbusy, err_cyc, c;
    bit consumed, pst, pbit, fin;
    fdat.delete();
    for (int i = 0; i < 8 * len; i++)
      fdat.push_back(zero ? 1'b0 : 1'($urandom_range(0, 1)));
    cap0.delete();
    cap1.delete();
    cap2.delete();
    ndone = '{0, 0, 0};
    done_cyc = '{-1, -1, -1};
    first_ov = -1;
    nerr = 0;
    nbusy = 0;
    err_cyc = -1;
    pst = 1'b0;
    pbit = 1'b0;
    fin = 1'b0;
    di = 0;
    nb0 = 0;
    seed = sd;
    length = 12'(len);
    start = 1'b1;
    out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    in_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    in_bit = (len > 0) ? fdat[0] : 1'b0;
    c = 0;
    while (c < 3000) begin
      @(negedge clk);
      if (pst)
        chk(ov[0] && ob[0] == pbit, {tag, " held bit"},
            int'(ob[0]), int'(pbit));
      pst = ov[0] && !out_ready && (nb0 < 16 || nb0 >= 16 + 8 * len);
      pbit = ob[0];
      if (ov[0] && first_ov < 0) first_ov = c;
      if (ov[0] && out_ready) begin
        cap0.push_back(ob[0]);
        nb0++;
      end
      if (ov[1] && out_ready) cap1.push_back(ob[1]);
      if (ov[2] && out_ready) cap2.push_back(ob[2]);
      consumed = in_valid && ir[0];
      for (int d = 0; d < 3; d++) begin
        if (dn[d]) begin
          ndone[d]++;
          done_cyc[d] = c;
        end
      end
      if (er[0]) begin
        nerr++;
        if (err_cyc < 0) err_cyc = c;
      end
      if (bz[0]) nbusy++;
      if (xerr ? (c >= 6) : (ndone[0] > 0 && ndone[1] > 0 && ndone[2] > 0)) begin
        fin = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (consumed) di++;
      in_bit = (di < 8 * len) ? fdat[di] : 1'($urandom_range(0, 1));
      in_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      c++;
    end
    if (xerr) begin
      chk(nerr == 1, {tag, " err pulses"}, nerr, 1);
      chk(err_cyc == 1, {tag, " err cycle"}, err_cyc, 1);
      chk(nbusy == 0, {tag, " busy cycles"}, nbusy, 0);
      chk(cap0.size() + cap1.size() + cap2.size() == 0,
          {tag, " beats"}, cap0.size(), 0);
    end else begin
      chk(fin, {tag, " done timeout"}, int'(fin), 1);
      chk(nerr == 0, {tag, " err pulses"}, nerr, 0);
      chk(first_ov == 1, {tag, " first valid cycle"}, first_ov, 1);
      cmp_model(0, sd, len, 24, h0, {tag, " n24"});
      cmp_model(1, sd, len, 48, h1, {tag, " n48"});
      cmp_model(2, sd, len, 2, h2, {tag, " n2"});
      chk(ndone[0] == 1 && ndone[1] == 1 && ndone[2] == 1,
          {tag, " done pulses"}, ndone[0] + ndone[1] + ndone[2], 3);
      chk(nbusy == done_cyc[0], {tag, " busy span"}, nbusy, done_cyc[0]);
      if (!stall)
        chk(done_cyc[0] - first_ov == h0, {tag, " done latency"},
            done_cyc[0] - first_ov, h0);
    end
    wait_idle(tag);
  endtask

  task automatic reset_mid_data();
    int c, nb, bad;
    seed = 7'h7F;
    length = 12'd4;
    start = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_bit = 1'b1;
    nb = 0;
    c = 0;
    while (nb < 32 && c < 200) begin
      @(negedge clk);
      if (ov[0] && out_ready) nb++;
      @(posedge clk);
      #1;
      start = 1'b0;
      in_bit = 1'($urandom_range(0, 1));
      c++;
    end
    chk(nb == 32, "reset reach mid data", nb, 32);
    #2;
    rst_n = 1'b0;
    #1;
    chk({ir[0], ov[0], ob[0], bz[0], dn[0], er[0]} == 6'b0,
        "reset abort outputs n24", int'({ir[0], ov[0], ob[0], bz[0], dn[0], er[0]}), 0);
    chk((ir | ov | ob | bz | dn | er) == 3'b0,
        "reset abort outputs all", int'(ir | ov | ob | bz | dn | er), 0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ((ov | dn | bz) != 3'b0) bad++;
    end
    chk(bad == 0, "reset quiet cycles", bad, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(7'h7F, 1, 1'b1, 1'b0, 48, 48, 30, 1'b0, "after reset");
    chk(cap_bits(0, 16) == 16'h0EF2, "after reset service",
        cap_bits(0, 16), 16'h0EF2);
  endtask

  task automatic start_held();
    int c, dcyc, nd;
    bit ok_idle, ok_restart;
    seed = 7'h7F;
    length = 12'd1;
    start = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_bit = 1'b0;
    dcyc = -1;
    nd = 0;
    ok_idle = 1'b0;
    ok_restart = 1'b0;
    c = 0;
    while (c < 200) begin
      @(negedge clk);
      if (dn[0]) begin
        nd++;
        if (dcyc < 0) dcyc = c;
      end
      if (dcyc >= 0 && c == dcyc + 1) ok_idle = !bz[0] && !ov[0];
      if (dcyc >= 0 && c == dcyc + 2) begin
        ok_restart = bz[0] && ov[0];
        break;
      end
      @(posedge clk);
      #1;
      c++;
    end
    chk(dcyc == 49, "held start done cycle", dcyc, 49);
    chk(nd == 1, "held start done pulses", nd, 1);
    chk(ok_idle, "held start idle gap", int'(ok_idle), 1);
    chk(ok_restart, "held start restart", int'(ok_restart), 1);
    wait_idle("held start");
  endtask

  initial begin
    tbl[0] = '{7'h7F, 1, 1'b1, 1'b0, 48, 48, 30, 1'b0};
    tbl[1] = '{7'h7F, 2, 1'b0, 1'b0, 48, 48, 38, 1'b0};
    tbl[2] = '{7'h7F, 3, 1'b0, 1'b0, 48, 48, 46, 1'b0};
    tbl[3] = '{7'h25, 5, 1'b0, 1'b0, 72, 96, 62, 1'b0};
    tbl[4] = '{7'h00, 3, 1'b0, 1'b0, 0, 0, 0, 1'b1};
    tbl[5] = '{7'h55, 0, 1'b0, 1'b0, 0, 0, 0, 1'b1};
    tbl[6] = '{7'h4B, 4, 1'b0, 1'b1, 72, 96, 54, 1'b0};
    tbl[7] = '{7'h7F, 4, 1'b0, 1'b1, 72, 96, 54, 1'b0};
    tbl[8] = '{7'h13, 4, 1'b0, 1'b1, 72, 96, 54, 1'b0};

    #3;
    chk((ir | ov | ob | bz | dn | er) == 3'b0, "reset state",
        int'(ir | ov | ob | bz | dn | er), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      run_frame(tbl[i].sd, tbl[i].len, tbl[i].zero, tbl[i].stall,
                tbl[i].t0, tbl[i].t1, tbl[i].t2, tbl[i].xerr,
                $sformatf("vec%0d", i));
      if (i == 0) begin
        chk(cap_bits(0, 16) == 16'h0EF2, "vec0 service",
            cap_bits(0, 16), 16'h0EF2);
        chk(cap_bits(16, 8) == 8'hC9, "vec0 psdu",
            cap_bits(16, 8), 8'hC9);
        chk(cap_bits(24, 6) == 0, "vec0 tail", cap_bits(24, 6), 0);
      end
    end

    reset_mid_data();
    start_held();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
